t05_sram_arbiter: RTL and testbench



---
 rtl/t05_sram_pkg.sv | 29 ++
 rtl/t05_rr_picker.sv | 51 +++++
 rtl/t05_sram_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_t05_sram_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t05_sram_pkg.sv
// ---------------------------------------------------------------------------
// t05_sram_pkg
// Shared definitions for the SRAM port arbiter: the bus-sequencer state
// encoding, the fixed requester slot assignment of the compression pipeline,
// and the base addresses of the SRAM tables the requesters work on.
// ---------------------------------------------------------------------------
package t05_sram_pkg;

    // Bus sequencer states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Requester slots; a lower index wins ties while the pointer is at 0.
    localparam int HIST  = 0;
    localparam int FLV   = 1;
    localparam int HTREE = 2;
    localparam int CB    = 3;
    localparam int TRANS = 4;

    // SRAM table regions.
    localparam logic [31:0] HIST_BASE  = 32'h3300_0000;
    localparam logic [31:0] HTREE_BASE = 32'h3200_0000;
    localparam logic [31:0] CB_BASE    = 32'h3400_0000;

endpackage

// File: rtl/t05_rr_picker.sv
// ---------------------------------------------------------------------------
// t05_rr_picker
// Combinational round-robin selection: finds the first set bit of `eligible`
// at or after `ptr`, wrapping modulo NREQ.
//
// Ports:
//   eligible  in   NREQ  candidate vector
//   ptr       in   IW    search start index (must be < NREQ)
//   grant     out  NREQ  one-hot winner, 0 when nothing is eligible
//   index     out  IW    winner index (0 when nothing is eligible)
//   found     out  1     any candidate present
// ---------------------------------------------------------------------------
module t05_rr_picker #(
    parameter int NREQ = 5,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   index,
    output logic            found
);

    int j;

    // Rotate, priority-encode and un-rotate folded into one scan: offset k
    // from the pointer maps back to absolute index j. Scanning from the
    // highest offset down lets the lowest eligible offset win.
    // NOTE: every output gets a default before the scan so no path through
    // the loop leaves a value unassigned, which would infer a latch.
    always_comb begin
        found = 1'b0;
        index = '0;
        grant = '0;
        j     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (eligible[j]) begin
                found = 1'b1;
                index = IW'(j);
            end
        end
        if (found) begin
            grant[index] = 1'b1;
        end
    end

endmodule

// File: rtl/t05_sram_arbiter.sv
// ---------------------------------------------------------------------------
// t05_sram_arbiter
// Round-robin arbiter and bus sequencer sharing the single wishbone-manager
// SRAM port among the compression-pipeline requesters. Each grant moves one
// word; a requester holding req_lock keeps the port for multi-word sequences.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_mask/req/req_we/req_lock   per-requester enable, request, direction,
//                                  hold-port flag (NREQ bits each)
//   req_addr/req_wdata/req_sel     packed per-requester address, write data,
//                                  byte selects (32/32/4 bits per requester)
//   grant               one-hot current owner, 0 when idle
//   ack                 one-cycle completion pulse at the owner's index
//   rdata               last completed read word
//   err                 pulses with ack when the bus never accepted the word
//   wr_en/r_en/select/addr/data_i  bus request outputs
//   busy_o/data_o       bus status and read data from the wishbone manager
// ---------------------------------------------------------------------------
module t05_sram_arbiter
    import t05_sram_pkg::*;
#(
    parameter int NREQ    = 5,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_mask,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ-1:0]      req_lock,
    input  logic [NREQ*32-1:0]   req_addr,
    input  logic [NREQ*32-1:0]   req_wdata,
    input  logic [NREQ*4-1:0]    req_sel,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      ack,
    output logic [31:0]          rdata,
    output logic                 err,
    output logic                 wr_en,
    output logic                 r_en,
    output logic [3:0]           select,
    output logic [31:0]          addr,
    output logic [31:0]          data_i,
    input  logic                 busy_o,
    input  logic [31:0]          data_o
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   gidx_q;
    logic            we_q;
    logic            abort_q;
    logic [WW-1:0]   wd_q;

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] pick_grant;
    logic [IW-1:0]   pick_idx;
    logic            pick_found;
    logic [IW-1:0]   src_idx;
    logic            keep;

    // Control strobes from the next-state logic.
    logic            latch;
    logic            release_port;
    logic            wd_inc;
    logic            abort_set;

    assign eligible = req & req_mask;

    t05_rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
        .eligible (eligible),
        .ptr      (ptr_q),
        .grant    (pick_grant),
        .index    (pick_idx),
        .found    (pick_found)
    );

    // A fresh grant loads the picked requester; a locked follow-on word
    // re-loads the current owner.
    assign src_idx = (state_q == S_IDLE) ? pick_idx : gidx_q;
    assign keep    = req_lock[gidx_q] & req[gidx_q] & req_mask[gidx_q];

    // NOTE: state and datapath registers use non-blocking assignments so all
    // of them update together from the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        latch        = 1'b0;
        release_port = 1'b0;
        wd_inc       = 1'b0;
        abort_set    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    latch   = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (busy_o) begin
                    state_d = S_WAIT;
                end else if (wd_q == WW'(TIMEOUT - 1)) begin
                    abort_set = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            S_WAIT: begin
                if (!busy_o) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (keep) begin
                    latch   = 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    release_port = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            gidx_q  <= '0;
            grant   <= '0;
            we_q    <= 1'b0;
            abort_q <= 1'b0;
            wd_q    <= '0;
            rdata   <= '0;
            addr    <= '0;
            data_i  <= '0;
            select  <= '0;
        end else begin
            if (latch) begin
                we_q   <= req_we[src_idx];
                addr   <= req_addr[32*src_idx +: 32];
                data_i <= req_wdata[32*src_idx +: 32];
                select <= req_sel[4*src_idx +: 4];
                if (state_q == S_IDLE) begin
                    gidx_q <= pick_idx;
                    grant  <= pick_grant;
                end
            end

            if (wd_inc) begin
                wd_q <= wd_q + WW'(1);
            end else if (state_q == S_DONE) begin
                wd_q <= '0;
            end

            if (abort_set) begin
                abort_q <= 1'b1;
            end else if (state_q == S_DONE) begin
                abort_q <= 1'b0;
            end

            // Only a read the bus actually served updates rdata.
            if (state_q == S_DONE && !abort_q && !we_q) begin
                rdata <= data_o;
            end

            // Leaving the port: the bus returns to idle values and the next
            // search starts just past the requester that was served.
            if (release_port) begin
                ptr_q  <= (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);
                grant  <= '0;
                we_q   <= 1'b0;
                addr   <= '0;
                data_i <= '0;
                select <= '0;
            end
        end
    end

    // Strobes and completion pulses decode from the state; gating with rst
    // drops them in the very cycle reset is asserted.
    assign wr_en = (state_q == S_ISSUE) && we_q && !rst;
    assign r_en  = (state_q == S_ISSUE) && !we_q && !rst;
    assign ack   = (state_q == S_DONE && !rst) ? grant : '0;
    assign err   = (state_q == S_DONE) && abort_q && !rst;

endmodule

// File: tb/tb_t05_sram_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_t05_sram_arbiter
// Directed stimulus with a scoreboard: each issued transaction pushes its
// expected completion; a monitor pops and compares on every ack pulse. A
// small bus model answers strobes with a programmable busy profile.
// ---------------------------------------------------------------------------
module tb_t05_sram_arbiter;

    localparam int NREQ = 5;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req_mask, req, req_we, req_lock;
    logic [NREQ*32-1:0]  req_addr, req_wdata;
    logic [NREQ*4-1:0]   req_sel;
    logic [NREQ-1:0]     grant, ack;
    logic [31:0]         rdata;
    logic                err, wr_en, r_en;
    logic [3:0]          select;
    logic [31:0]         addr, data_i;
    logic                busy_o;
    logic [31:0]         data_o;

    t05_sram_arbiter #(.NREQ(NREQ), .TIMEOUT(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_mask  (req_mask),
        .req       (req),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_sel   (req_sel),
        .grant     (grant),
        .ack       (ack),
        .rdata     (rdata),
        .err       (err),
        .wr_en     (wr_en),
        .r_en      (r_en),
        .select    (select),
        .addr      (addr),
        .data_i    (data_i),
        .busy_o    (busy_o),
        .data_o    (data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        int          idx;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];

    task automatic expect_txn(input int idx, input logic we, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] s,
                              input logic e, input logic [31:0] rd);
        exp_t x;
        x.idx = idx; x.we = we; x.addr = a; x.wdata = d; x.sel = s; x.err = e; x.rdata = rd;
        exp_q.push_back(x);
    endtask

    task automatic set_fields(input int i, input logic we, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] s, input logic lk);
        req_we[i]            = we;
        req_addr[i*32 +: 32] = a;
        req_wdata[i*32 +: 32] = d;
        req_sel[i*4 +: 4]    = s;
        req_lock[i]          = lk;
    endtask

    // ---------------- bus model ----------------
    int          busy_delay = 2;
    int          busy_hold  = 3;
    bit          never_busy = 1'b0;
    logic [31:0] bus_rdata  = '0;
    logic        obs_we;
    logic [31:0] obs_addr, obs_data;
    logic [3:0]  obs_sel;

    initial begin
        busy_o = 1'b0;
        data_o = '0;
        forever begin
            @(negedge clk);
            if (wr_en || r_en) begin
                obs_we   = wr_en;
                obs_addr = addr;
                obs_data = data_i;
                obs_sel  = select;
                if (never_busy) begin
                    while (wr_en || r_en) @(negedge clk);
                end else begin
                    repeat (busy_delay - 1) @(negedge clk);
                    busy_o = 1'b1;
                    data_o = bus_rdata;
                    repeat (busy_hold) @(negedge clk);
                    busy_o = 1'b0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ack !== '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 64'(ack), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_index", 64'(ack), 64'(1) << e.idx);
                    check("grant_at_ack", 64'(grant), 64'(1) << e.idx);
                    check("err_at_ack", 64'(err), 64'(e.err));
                    check("bus_we", 64'(obs_we), 64'(e.we));
                    check("bus_addr", 64'(obs_addr), 64'(e.addr));
                    check("bus_data", 64'(obs_data), 64'(e.wdata));
                    check("bus_sel", 64'(obs_sel), 64'(e.sel));
                    @(negedge clk);
                    check("rdata_after_ack", 64'(rdata), 64'(e.rdata));
                end
            end else if (err !== 1'b0) begin
                check("stray_err", 64'(err), 64'd0);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_acks(input int n, input int budget, input string tag);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (ack !== '0) seen++;
        end
        check({tag, "_ack_count"}, 64'(seen), 64'(n));
    endtask

    task automatic wait_busy(input int budget, input string tag);
        int cyc = 0;
        while (busy_o !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_busy_seen"}, 64'(busy_o), 64'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_grant"},  64'(grant),  64'd0);
        check({tag, "_ack"},    64'(ack),    64'd0);
        check({tag, "_rdata"},  64'(rdata),  64'd0);
        check({tag, "_err"},    64'(err),    64'd0);
        check({tag, "_strobe"}, 64'({wr_en, r_en}), 64'd0);
        check({tag, "_addr"},   64'(addr),   64'd0);
        check({tag, "_data_i"}, 64'(data_i), 64'd0);
        check({tag, "_select"}, 64'(select), 64'd0);
    endtask

    initial begin
        #200us;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    // ---------------- stimulus ----------------
    initial begin
        int cycles;
        rst       = 1'b1;
        req_mask  = '1;
        req       = '0;
        req_we    = '0;
        req_lock  = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_sel   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        // Single read on requester 0, busy 2 cycles after strobe for 3 cycles.
        bus_rdata = 32'hDEAD_BEEF; busy_delay = 2; busy_hold = 3;
        set_fields(0, 1'b0, 32'h3300_0010, 32'h0, 4'hF, 1'b0);
        expect_txn(0, 1'b0, 32'h3300_0010, 32'h0, 4'hF, 1'b0, 32'hDEAD_BEEF);
        req[0] = 1'b1;
        @(negedge clk);
        check("t1_r_en_latency", 64'(r_en), 64'd1);
        check("t1_wr_en", 64'(wr_en), 64'd0);
        check("t1_grant", 64'(grant), 64'b00001);
        req[0] = 1'b0;
        req_addr[31:0] = 32'hFFFF_FFFF;   // latched copy must be unaffected
        wait_acks(1, 30, "t1");
        @(negedge clk);
        check("t1_grant_idle", 64'(grant), 64'd0);
        check("t1_addr_idle", 64'(addr), 64'd0);

        // Contention between 1 and 3, unlocked, held: 1,3,1,3.
        bus_rdata = 32'hCAFE_0001; busy_delay = 1; busy_hold = 1;
        set_fields(1, 1'b0, 32'h3300_0100, 32'h0, 4'hF, 1'b0);
        set_fields(3, 1'b1, 32'h3400_0000, 32'h5555_AAAA, 4'h3, 1'b0);
        expect_txn(1, 1'b0, 32'h3300_0100, 32'h0, 4'hF, 1'b0, 32'hCAFE_0001);
        expect_txn(3, 1'b1, 32'h3400_0000, 32'h5555_AAAA, 4'h3, 1'b0, 32'hCAFE_0001);
        expect_txn(1, 1'b0, 32'h3300_0100, 32'h0, 4'hF, 1'b0, 32'hCAFE_0001);
        expect_txn(3, 1'b1, 32'h3400_0000, 32'h5555_AAAA, 4'h3, 1'b0, 32'hCAFE_0001);
        req[1] = 1'b1; req[3] = 1'b1;
        wait_acks(4, 60, "t2");
        req[1] = 1'b0; req[3] = 1'b0;
        @(negedge clk);

        // Locked 4-word write burst on 3 while 2 waits.
        bus_rdata = 32'h0000_2222;
        set_fields(3, 1'b1, 32'h3400_0010, 32'h11, 4'hF, 1'b1);
        set_fields(2, 1'b0, 32'h3200_0008, 32'h0, 4'hF, 1'b0);
        expect_txn(3, 1'b1, 32'h3400_0010, 32'h11, 4'hF, 1'b0, 32'hCAFE_0001);
        expect_txn(3, 1'b1, 32'h3400_0014, 32'h22, 4'hF, 1'b0, 32'hCAFE_0001);
        expect_txn(3, 1'b1, 32'h3400_0018, 32'h33, 4'hF, 1'b0, 32'hCAFE_0001);
        expect_txn(3, 1'b1, 32'h3400_001C, 32'h44, 4'hF, 1'b0, 32'hCAFE_0001);
        expect_txn(2, 1'b0, 32'h3200_0008, 32'h0, 4'hF, 1'b0, 32'h0000_2222);
        req[3] = 1'b1;
        @(negedge clk);
        req[2] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            wait_acks(1, 30, "t3_word");
            set_fields(3, 1'b1, 32'h3400_0010 + 32'(4 * k), 32'(8'h11 * (k + 1)), 4'hF, 1'b1);
            @(negedge clk);
            check("t3_grant_held", 64'(grant), 64'b01000);
        end
        wait_acks(1, 30, "t3_last");
        req[3] = 1'b0; req_lock[3] = 1'b0;
        wait_acks(1, 30, "t3_req2");
        req[2] = 1'b0;
        @(negedge clk);

        // Watchdog: bus never goes busy.
        never_busy = 1'b1;
        set_fields(4, 1'b0, 32'h3300_0040, 32'h0, 4'hF, 1'b0);
        expect_txn(4, 1'b0, 32'h3300_0040, 32'h0, 4'hF, 1'b1, 32'h0000_2222);
        req[4] = 1'b1;
        @(negedge clk);
        check("t4_r_en", 64'(r_en), 64'd1);
        req[4] = 1'b0;
        cycles = 0;
        while (ack === '0 && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        check("t4_issue_cycles", 64'(cycles), 64'd64);
        @(negedge clk);
        check("t4_grant_idle", 64'(grant), 64'd0);
        check("t4_r_en_idle", 64'(r_en), 64'd0);
        never_busy = 1'b0;

        // Masked request is ignored; unmasked, req dropped mid-WAIT.
        busy_delay = 1; busy_hold = 3; bus_rdata = 32'h0000_7777;
        req_mask[2] = 1'b0;
        set_fields(2, 1'b0, 32'h3200_000C, 32'h0, 4'hF, 1'b0);
        req[2] = 1'b1;
        repeat (10) @(negedge clk);
        check("t5_masked_grant", 64'(grant), 64'd0);
        expect_txn(2, 1'b0, 32'h3200_000C, 32'h0, 4'hF, 1'b0, 32'h0000_7777);
        req_mask[2] = 1'b1;
        wait_busy(20, "t5");
        @(negedge clk);
        req[2] = 1'b0;
        wait_acks(1, 20, "t5");
        repeat (2) @(negedge clk);

        // Reset during WAIT: no ack, outputs cleared, pointer back to 0.
        busy_delay = 1; busy_hold = 4;
        set_fields(2, 1'b0, 32'h3200_0000, 32'h0, 4'hF, 1'b0);
        req[2] = 1'b1;
        @(negedge clk);
        req[2] = 1'b0;
        wait_busy(20, "t6");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("t6_reset");
        rst = 1'b0;
        repeat (6) @(negedge clk);
        busy_hold = 1;
        set_fields(0, 1'b1, 32'h3300_0100, 32'hA0, 4'hF, 1'b0);
        set_fields(4, 1'b1, 32'h3300_0200, 32'hB4, 4'h1, 1'b0);
        expect_txn(0, 1'b1, 32'h3300_0100, 32'hA0, 4'hF, 1'b0, 32'h0);
        expect_txn(4, 1'b1, 32'h3300_0200, 32'hB4, 4'h1, 1'b0, 32'h0);
        req[0] = 1'b1; req[4] = 1'b1;
        @(negedge clk);
        check("t6_first_grant", 64'(grant), 64'b00001);
        wait_acks(1, 20, "t6_req0");
        req[0] = 1'b0;
        wait_acks(1, 20, "t6_req4");
        req[4] = 1'b0;

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
